// File: rtl/z80_bus_pkg.sv
// Z80 bus master shared definitions: command encodings, FSM state
// encoding and the default T-state length in system clocks.
package z80_bus_pkg;

    localparam int TSTATE_CLKS_DEF = 2;

    typedef enum logic [1:0] {
        CMD_MEMRD = 2'b00,
        CMD_MEMWR = 2'b01,
        CMD_IORD  = 2'b10,
        CMD_IOWR  = 2'b11
    } cmd_type_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_T1   = 3'd1,
        ST_T2   = 3'd2,
        ST_TW   = 3'd3,
        ST_T3   = 3'd4,
        ST_DONE = 3'd5
    } state_e;

    // Bit 1 of the command type selects IO space, bit 0 selects a write.
    function automatic logic cmd_is_io(input logic [1:0] t);
        return t[1];
    endfunction

    function automatic logic cmd_is_wr(input logic [1:0] t);
        return t[0];
    endfunction

endpackage

// File: rtl/z80_tstate_timer.sv
// T-state timer: down-counter that measures one Z80 T-state in system clocks.
// Ports:
//   clk, reset_n  clock, asynchronous active-low reset
//   restart       reload the counter (asserted on every state entry)
//   last          high on the last system clock of the current T-state
module z80_tstate_timer
    import z80_bus_pkg::*;
#(
    parameter int TSTATE_CLKS = TSTATE_CLKS_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic restart,
    output logic last
);

    localparam logic [7:0] RELOAD = 8'(TSTATE_CLKS - 1);

    logic [7:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cnt <= '0;
        else if (restart)
            cnt <= RELOAD;
        else if (cnt != '0)
            cnt <= cnt - 8'd1;
    end

    assign last = (cnt == '0);

endmodule

// File: rtl/z80_bus_master.sv
// Z80 bus master: turns single commands into Z80 memory / IO bus cycles
// (T1, T2, optional TW, T3) and returns a one-clock response pulse.
// Ports:
//   clk, reset_n                       clock, asynchronous active-low reset
//   cmd_valid/cmd_ready/cmd_type/
//   cmd_addr/cmd_wdata                 command handshake
//   rsp_valid/rsp_rdata/rsp_err        response (rsp_err = wait timeout)
//   A, D_out, D_oe, D_in               address and split data bus
//   MREQ_n, IORQ_n, RD_n, WR_n         active-low strobes
//   WAIT_n                             synchronised wait request
// Build option: define Z80_BUS_MASTER_WAIT_EN to honour WAIT_n with a
// wait-state counter and timeout abort; otherwise WAIT_n is ignored.
module z80_bus_master
    import z80_bus_pkg::*;
#(
    parameter int TSTATE_CLKS  = TSTATE_CLKS_DEF,
    parameter int WAIT_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_type,
    input  logic [15:0] cmd_addr,
    input  logic [7:0]  cmd_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        rsp_err,
    output logic [15:0] A,
    output logic [7:0]  D_out,
    output logic        D_oe,
    input  logic [7:0]  D_in,
    output logic        MREQ_n,
    output logic        IORQ_n,
    output logic        RD_n,
    output logic        WR_n,
    input  logic        WAIT_n
);

    state_e      state_q, state_d;
    logic [1:0]  type_q;
    logic [15:0] addr_q;
    logic [7:0]  wdata_q;
    logic [7:0]  rdata_q;
    logic        last;
    logic        restart;
    logic        strobe_ph;   // T2/TW/T3: select and RD/WR strobes active
    logic        drive_ph;    // T1..T3: write data driven

    // IDLE reloads continuously so T1 starts with a full count; every later
    // state change happens on a T-state boundary, which also reloads.
    assign restart = (state_q == ST_IDLE) || (state_q == ST_DONE) || last;

    z80_tstate_timer #(.TSTATE_CLKS(TSTATE_CLKS)) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .restart (restart),
        .last    (last)
    );

`ifdef Z80_BUS_MASTER_WAIT_EN
    logic [7:0] wcnt_q;
    logic       err_q;
    logic       wcnt_inc;
    logic       abort;
`else
    logic unused_wait;
    assign unused_wait = WAIT_n ^ (WAIT_TIMEOUT != 0);
`endif

    always_comb begin
        state_d = state_q;
`ifdef Z80_BUS_MASTER_WAIT_EN
        wcnt_inc = 1'b0;
        abort    = 1'b0;
`endif
        case (state_q)
            ST_IDLE: if (cmd_valid) state_d = ST_T1;
            ST_T1:   if (last) state_d = ST_T2;
            ST_T2: begin
                if (last) begin
                    state_d = ST_T3;
                    if (cmd_is_io(type_q)) begin
                        state_d = ST_TW;   // automatic IO wait, not counted
                    end
`ifdef Z80_BUS_MASTER_WAIT_EN
                    else if (!WAIT_n) begin
                        if (wcnt_q == 8'(WAIT_TIMEOUT)) begin
                            abort   = 1'b1;
                            state_d = ST_DONE;
                        end else begin
                            wcnt_inc = 1'b1;
                            state_d  = ST_TW;
                        end
                    end
`endif
                end
            end
            ST_TW: begin
                if (last) begin
                    state_d = ST_T3;
`ifdef Z80_BUS_MASTER_WAIT_EN
                    if (!WAIT_n) begin
                        if (wcnt_q == 8'(WAIT_TIMEOUT)) begin
                            abort   = 1'b1;
                            state_d = ST_DONE;
                        end else begin
                            wcnt_inc = 1'b1;
                            state_d  = ST_TW;
                        end
                    end
`endif
                end
            end
            ST_T3:   if (last) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            type_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && cmd_valid) begin
                type_q  <= cmd_type;
                addr_q  <= cmd_addr;
                wdata_q <= cmd_wdata;
            end
            if (state_q == ST_T3 && last && !cmd_is_wr(type_q))
                rdata_q <= D_in;
        end
    end

`ifdef Z80_BUS_MASTER_WAIT_EN
    // Counter stops at WAIT_TIMEOUT (abort fires instead of incrementing),
    // so it never wraps.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wcnt_q <= '0;
            err_q  <= 1'b0;
        end else if (state_q == ST_IDLE && cmd_valid) begin
            wcnt_q <= '0;
            err_q  <= 1'b0;
        end else begin
            if (wcnt_inc) wcnt_q <= wcnt_q + 8'd1;
            if (abort)    err_q  <= 1'b1;
        end
    end
    assign rsp_err = (state_q == ST_DONE) && err_q;
`else
    assign rsp_err = 1'b0;
`endif

    // Bus outputs decode straight from flops so reset forces them at once.
    assign strobe_ph = (state_q == ST_T2) || (state_q == ST_TW) || (state_q == ST_T3);
    assign drive_ph  = strobe_ph || (state_q == ST_T1);

    assign cmd_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_DONE);
    assign rsp_rdata = rdata_q;
    assign A         = addr_q;
    assign D_out     = wdata_q;
    assign D_oe      = drive_ph && cmd_is_wr(type_q);
    assign MREQ_n    = !(strobe_ph && !cmd_is_io(type_q));
    assign IORQ_n    = !(strobe_ph &&  cmd_is_io(type_q));
    assign RD_n      = !(strobe_ph && !cmd_is_wr(type_q));
    assign WR_n      = !(strobe_ph &&  cmd_is_wr(type_q));

endmodule

// File: tb/tb_z80_bus_master.sv
// Self-checking bench for z80_bus_master. The expected timing of each bus
// cycle is computed from the cycle rules (T-state counts times TSTATE_CLKS);
// wait-state checks are built only when Z80_BUS_MASTER_WAIT_EN is defined.
module tb_z80_bus_master;

    localparam int TC = 2;
    localparam int WT = 255;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_type;
    logic [15:0] cmd_addr;
    logic [7:0]  cmd_wdata;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_err;
    logic [15:0] A;
    logic [7:0]  D_out;
    logic        D_oe;
    logic [7:0]  D_in;
    logic        MREQ_n, IORQ_n, RD_n, WR_n;
    logic        WAIT_n;

    int n_assert = 0;
    int n_fail   = 0;
    int overlap  = 0;
    logic [7:0] exp_rdata = 8'h00;

    z80_bus_master #(.TSTATE_CLKS(TC), .WAIT_TIMEOUT(WT)) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .A(A), .D_out(D_out), .D_oe(D_oe), .D_in(D_in),
        .MREQ_n(MREQ_n), .IORQ_n(IORQ_n), .RD_n(RD_n), .WR_n(WR_n),
        .WAIT_n(WAIT_n)
    );

    always #5 clk = ~clk;

    // Strobe exclusivity watched over the whole run.
    always @(negedge clk) begin
        if ((!RD_n && !WR_n) || (!MREQ_n && !IORQ_n)) overlap <= overlap + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Runs one command from IDLE (called at #1 after a rising edge) and
    // returns at #1 after the edge following DONE.
    task automatic run_cmd(input logic [1:0] t, input logic [15:0] a, input logic [7:0] wd,
                           input logic [7:0] di, input int nwait);
        int io, wr, ntw, ab, exp_strb, exp_lat, lat;
        int sel_lo, rw_lo, bad_lo, oe_cnt, dbad, abad, rdybad, donebad;
        logic err_seen;
        io = int'(t[1]);
        wr = int'(t[0]);
`ifdef Z80_BUS_MASTER_WAIT_EN
        begin
            int w;
            // IO: the automatic TW absorbs the first wait request.
            w  = io != 0 ? ((nwait > 0) ? nwait - 1 : 0) : nwait;
            ab = (w > WT) ? 1 : 0;
            ntw = io + (ab != 0 ? WT : w);
        end
`else
        ab  = 0;
        ntw = io;
`endif
        exp_strb = TC * (1 + ntw + (ab != 0 ? 0 : 1));
        exp_lat  = 1 + TC + exp_strb;
        sel_lo = 0; rw_lo = 0; bad_lo = 0; oe_cnt = 0;
        dbad = 0; abad = 0; rdybad = 0; donebad = 0; lat = 0;
        err_seen = 1'b0;

        cmd_valid = 1'b1; cmd_type = t; cmd_addr = a; cmd_wdata = wd; D_in = di;
        chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_wdata = ~wd;   // latched copy must be what drives D_out
        for (int c = 1; c <= 4000 && lat == 0; c++) begin
            WAIT_n = !(c >= 1 + TC && c < 1 + TC + nwait * TC);
            if (A !== a) abad++;
            if (rsp_valid) begin
                lat = c;
                err_seen = rsp_err;
                if ({MREQ_n, IORQ_n, RD_n, WR_n} !== 4'hF || D_oe !== 1'b0) donebad++;
                chk("rdata", 32'(rsp_rdata), 32'(ab == 0 && wr == 0 ? di : exp_rdata));
            end else begin
                if (cmd_ready) rdybad++;
                if ((io != 0 ? IORQ_n : MREQ_n) === 1'b0) sel_lo++;
                if ((io != 0 ? MREQ_n : IORQ_n) === 1'b0) bad_lo++;
                if ((wr != 0 ? WR_n : RD_n) === 1'b0) rw_lo++;
                if ((wr != 0 ? RD_n : WR_n) === 1'b0) bad_lo++;
                if (D_oe === 1'b1) begin
                    oe_cnt++;
                    if (D_out !== wd) dbad++;
                end
                @(posedge clk); #1;
            end
        end
        WAIT_n = 1'b1;
        if (ab == 0 && wr == 0) exp_rdata = di;
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("select_low_clks", 32'(sel_lo), 32'(exp_strb));
        chk("rdwr_low_clks", 32'(rw_lo), 32'(exp_strb));
        chk("wrong_strobe", 32'(bad_lo), 32'd0);
        chk("d_oe_clks", 32'(oe_cnt), 32'(wr != 0 ? exp_strb + TC : 0));
        chk("d_out", 32'(dbad), 32'd0);
        chk("addr_hold", 32'(abad), 32'd0);
        chk("ready_busy", 32'(rdybad), 32'd0);
        chk("done_outputs", 32'(donebad), 32'd0);
        chk("rsp_err", 32'(err_seen), 32'(ab));
        @(posedge clk); #1;
        chk("rsp_valid_one_clk", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        int lat, rv;
        reset_n = 1'b0; cmd_valid = 1'b0; cmd_type = 2'b00; cmd_addr = '0;
        cmd_wdata = '0; D_in = '0; WAIT_n = 1'b1;
        #3;
        chk("rst_strobes", 32'({MREQ_n, IORQ_n, RD_n, WR_n}), 32'hF);
        chk("rst_doe", 32'(D_oe), 32'd0);
        chk("rst_addr", 32'(A), 32'd0);
        chk("rst_dout", 32'(D_out), 32'd0);
        chk("rst_rsp", 32'({rsp_valid, rsp_err}), 32'd0);
        chk("rst_rdata", 32'(rsp_rdata), 32'd0);
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_rst", 32'(cmd_ready), 32'd1);

        // Directed wait-free cycles.
        run_cmd(2'b00, 16'h8123, 8'h00, 8'h5A, 0);
        run_cmd(2'b01, 16'h8000, 8'hA5, 8'h33, 0);
        run_cmd(2'b10, 16'h0001, 8'h00, 8'hC3, 0);
        run_cmd(2'b11, 16'h00FE, 8'h7E, 8'h11, 0);

`ifdef Z80_BUS_MASTER_WAIT_EN
        run_cmd(2'b00, 16'h1234, 8'h00, 8'h99, 3);     // 3 TW, latency 13
        run_cmd(2'b00, 16'h4321, 8'h00, 8'hEE, 1000);  // timeout abort
        run_cmd(2'b10, 16'h0040, 8'h00, 8'h42, 1000);  // IO timeout abort
`endif

        // Randomized commands; in the wait-disabled build WAIT_n noise must be ignored.
        for (int i = 0; i < 30; i++) begin
            run_cmd(2'($urandom_range(0, 3)), 16'($urandom), 8'($urandom),
                    8'($urandom), int'($urandom_range(0, 3)));
        end

        // Reset in the middle of T2 of a write.
        cmd_valid = 1'b1; cmd_type = 2'b01; cmd_addr = 16'hBEEF; cmd_wdata = 8'h3C;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        for (int i = 0; i < TC; i++) begin @(posedge clk); #1; end
        chk("mid_t2_wr_low", 32'(WR_n), 32'd0);
        reset_n = 1'b0;
        #1;
        chk("arst_strobes", 32'({MREQ_n, IORQ_n, RD_n, WR_n}), 32'hF);
        chk("arst_doe", 32'(D_oe), 32'd0);
        chk("arst_addr_dout", 32'({A, D_out}), 32'd0);
        chk("arst_rdata", 32'(rsp_rdata), 32'd0);
        exp_rdata = 8'h00;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("arst_ready", 32'(cmd_ready), 32'd1);
        rv = 0;
        for (int i = 0; i < 20; i++) begin
            if (rsp_valid) rv++;
            @(posedge clk); #1;
        end
        chk("arst_no_rsp", 32'(rv), 32'd0);

        // Back-to-back with cmd_valid held high.
        D_in = 8'h6D;
        cmd_valid = 1'b1; cmd_type = 2'b00; cmd_addr = 16'h2222;
        @(posedge clk); #1;
        cmd_type = 2'b01; cmd_addr = 16'h3333; cmd_wdata = 8'h44;
        lat = 0;
        for (int c = 1; c <= 100 && lat == 0; c++) begin
            if (rsp_valid) lat = c;
            else begin @(posedge clk); #1; end
        end
        chk("b2b_lat1", 32'(lat), 32'(3 * TC + 1));
        chk("b2b_rdata1", 32'(rsp_rdata), 32'h6D);
        @(posedge clk); #1;
        chk("b2b_idle_gap", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;
        chk("b2b_second_hs", 32'({cmd_ready, A}), 32'h3333);
        cmd_valid = 1'b0;
        lat = 0;
        for (int c = 1; c <= 100 && lat == 0; c++) begin
            if (rsp_valid) lat = c;
            else begin @(posedge clk); #1; end
        end
        chk("b2b_lat2", 32'(lat), 32'(3 * TC + 1));
        @(posedge clk); #1;

        chk("strobe_overlap", 32'(overlap), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/z80_bus_master.md
Z80_BUS_MASTER -- requirements
Module: z80_bus_master

Interface
REQ-001 Parameter TSTATE_CLKS, default 2, clk cycles per Z80 T-state (legal range 1-255).
REQ-002 Parameter WAIT_TIMEOUT, default 255, maximum consecutive wait T-states before an abort.
REQ-003 clk  in  1  single system clock; every flop is on its rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 cmd_valid  in  1  a command is offered.
REQ-006 cmd_ready  out  1  the master is idle and accepts a command.
REQ-007 cmd_type  in  2  00 MEMRD, 01 MEMWR, 10 IORD, 11 IOWR.
REQ-008 cmd_addr  in  16  bus address.
REQ-009 cmd_wdata  in  8  write data.
REQ-010 rsp_valid  out  1  one-clock pulse at the end of a cycle.
REQ-011 rsp_rdata  out  8  read data; holds its value until the next read.
REQ-012 rsp_err  out  1  qualifies rsp_valid; set when the cycle aborted on wait timeout.
REQ-013 A  out  16  address bus.
REQ-014 D_out / D_oe / D_in  out/out/in  8/1/8  split data bus; the top level builds the tristate.
REQ-015 MREQ_n, IORQ_n, RD_n, WR_n  out  1 each  active-low strobes.
REQ-016 WAIT_n  in  1  active-low wait request from the target; already synchronised at the top level.

Function
REQ-017 States: IDLE, T1, T2, TW, T3, DONE; each T-state lasts exactly TSTATE_CLKS clocks.
REQ-018 cmd_ready shall be 1 only in IDLE; a handshake (cmd_valid & cmd_ready) latches type, address and data and enters T1 on the next clock.
REQ-019 T1: A shall equal the latched address; all strobes high; D_oe=0, except writes, which assert D_oe in T1.
REQ-020 T2, TW, T3 on a read: MREQ_n (memory) or IORQ_n (IO) low, and RD_n low.
REQ-021 T2, TW, T3 on a write: the same select strobe low and WR_n low; D_out equals the latched data.
REQ-022 IO cycles shall always insert exactly one automatic TW after T2.
REQ-023 WAIT_n shall be sampled on the last clock of T2 and of each TW; while it is low, a further TW is inserted.
REQ-024 D_in shall be captured into rsp_rdata on the last clock of T3 of a read.
REQ-025 DONE lasts one clock: all strobes high, rsp_valid=1, D_oe=0; A holds the address; the next state is IDLE.
REQ-026 Wait-free latency from handshake to rsp_valid: memory 3*TSTATE_CLKS+1 clocks, IO 4*TSTATE_CLKS+1 clocks.
REQ-027 A second command shall not be accepted before rsp_valid has pulsed; back-to-back commands therefore have one IDLE clock between them.
REQ-028 RD_n and WR_n shall never be low simultaneously, and MREQ_n and IORQ_n shall never be low simultaneously.
REQ-029 Wait counter: 8 bits, counts TW states caused by WAIT_n; it shall not wrap.
REQ-030 When the wait counter reaches WAIT_TIMEOUT, the cycle goes to DONE with rsp_err=1; rsp_rdata is unchanged on an aborted read.

Reset
REQ-031 Assertion of reset_n (low) shall immediately force IDLE, all strobes 1, D_oe 0, A 0, D_out 0, rsp_valid 0, rsp_err 0, rsp_rdata 0, and clear all counters, including when a cycle is in progress.
REQ-032 After reset release, cmd_ready shall be 1 on the first clock.

Configuration
REQ-033 Macro Z80_BUS_MASTER_WAIT_EN: when defined, REQ-023, REQ-029 and REQ-030 apply.
REQ-034 When Z80_BUS_MASTER_WAIT_EN is undefined, WAIT_n is ignored, no target-requested TW occurs, rsp_err is tied to 0, and the IO automatic TW remains.

Structure
REQ-035 Package z80_bus_pkg shall hold the cmd_type encodings, the state encoding and the default TSTATE_CLKS.
REQ-036 Sub-module z80_tstate_timer shall hold the TSTATE_CLKS down-counter and produce a last-clock-of-T-state strobe; it is reset by reset_n and restarted on every state entry.

Verification
REQ-037 TSTATE_CLKS=2, MEMRD 0x8123 with D_in=0x5A and WAIT_n=1 -> MREQ_n/RD_n low for 4 clocks, rsp_valid 7 clocks after the handshake, rsp_rdata=0x5A, rsp_err=0.
REQ-038 MEMWR 0x8000 with data 0xA5 -> D_oe high from T1 until DONE, WR_n low for 4 clocks, D_out=0xA5 throughout, rsp_valid after 7 clocks.
REQ-039 IORD 0x0001 -> IORQ_n low for 6 clocks (including the auto TW), rsp_valid after 9 clocks.
REQ-040 WAIT_EN defined, MEMRD with WAIT_n low for 3 T-states -> 3 extra TW, latency 13 clocks; with WAIT_n held low -> rsp_err=1 after 255 TW.
REQ-041 Reset asserted mid-T2 of a write -> strobes high and D_oe 0 in the same cycle; after release cmd_ready=1 and no rsp_valid is produced.
REQ-042 cmd_valid held high across two commands -> the second handshake occurs exactly one clock after rsp_valid, and no strobe overlap occurs at any time.
